// File: rtl/tns15_codec.sv
// ---------------------------------------------------------------------------
// tns15_codec
// Ternary-neighbour-safe codec for a 15-wire TSV bundle.
//
// TNS_encoder_15 : registers a 15-bit binary word onto five 3-wire groups.
//                  Each group carries one base-7 digit. The pattern for
//                  digit 6 depends on the group's previous b2, which keeps
//                  worst-case crosstalk transitions off the bundle.
// TNS_dec_15     : stateless combinational decoder on the receiving die.
// tns15_codec    : wrapper that ties encoder and decoder back to back.
//
// Ports (tns15_codec):
//   datain  in  15  binary data word (legal range 0..16806)
//   clock   in  1   rising-edge clock
//   tsv     out 15  registered TSV levels
//   reset   in  1   synchronous active-high reset
//   dataout out 15  decoded word (combinational from tsv)
//
// Build option: TNS_RANGE_CHECK_EN
//   defined   : datain >= 16807 is illegal, and tsv holds its previous value
//   undefined : datain is encoded modulo 16807
// ---------------------------------------------------------------------------

module TNS_encoder_15 (
  input  logic [14:0] datain,
  input  logic        clock,
  output logic [14:0] tsv,
  input  logic        reset
);

  localparam logic [14:0] TNS06_C = 15'd16807;

  logic        in_range_s;
  logic [14:0] val_s;
  logic [14:0] quot_s [0:5];
  logic [2:0]  digit_s [0:4];
  logic [14:0] next_s;

  // Digit-to-pattern map. Digit 6 uses 110 or 001, chosen so that it
  // toggles b2 away from the level it held in the previous cycle.
  function automatic logic [2:0] enc_digit(input logic [2:0] d, input logic prev_b2);
    logic [2:0] p;
    case (d)
      3'd0:    p = 3'b000;
      3'd1:    p = 3'b010;
      3'd2:    p = 3'b011;
      3'd3:    p = 3'b100;
      3'd4:    p = 3'b101;
      3'd5:    p = 3'b111;
      3'd6:    p = prev_b2 ? 3'b001 : 3'b110;
      default: p = 3'b000;
    endcase
    return p;
  endfunction

  // Range reduction, base-7 digit extraction and per-group pattern selection.
  always_comb begin
    in_range_s = (datain < TNS06_C);
    if (in_range_s) begin
      val_s = datain;
    end else begin
      // Largest input is 32767 < 2*16807, so one subtraction is a full modulo.
      val_s = datain - TNS06_C;
    end
    quot_s[0] = val_s;
    for (int j = 0; j < 5; j++) begin
      digit_s[j]  = 3'(quot_s[j] % 15'd7);
      quot_s[j+1] = quot_s[j] / 15'd7;
    end
    next_s = 15'd0;
    for (int j = 0; j < 5; j++) begin
      next_s[3*j +: 3] = enc_digit(digit_s[j], tsv[3*j+2]);
    end
  end

  // TSV register: the only state in the encoder; b2 history is read back from it.
  always_ff @(posedge clock) begin
    if (reset) begin
      tsv <= 15'd0;
    end
`ifdef TNS_RANGE_CHECK_EN
    else if (!in_range_s) begin
      tsv <= tsv;
    end
`endif
    else begin
      tsv <= next_s;
    end
  end

endmodule

module TNS_dec_15 (
  input  logic [14:0] tsv,
  output logic [14:0] dataout
);

  logic [14:0] d_s [0:4];

  // Pattern-to-digit map; both digit-6 patterns decode to 6.
  function automatic logic [2:0] dec_group(input logic [2:0] p);
    logic [2:0] d;
    case (p)
      3'b000:  d = 3'd0;
      3'b010:  d = 3'd1;
      3'b011:  d = 3'd2;
      3'b100:  d = 3'd3;
      3'b101:  d = 3'd4;
      3'b111:  d = 3'd5;
      3'b001:  d = 3'd6;
      3'b110:  d = 3'd6;
      default: d = 3'd0;
    endcase
    return d;
  endfunction

  // Weighted sum of digits; maximum 16806 fits in 15 bits.
  always_comb begin
    for (int j = 0; j < 5; j++) begin
      d_s[j] = {12'd0, dec_group(tsv[3*j +: 3])};
    end
    dataout = d_s[0]
            + d_s[1] * 15'd7
            + d_s[2] * 15'd49
            + d_s[3] * 15'd343
            + d_s[4] * 15'd2401;
  end

endmodule

module tns15_codec (
  input  logic [14:0] datain,
  input  logic        clock,
  output logic [14:0] tsv,
  input  logic        reset,
  output logic [14:0] dataout
);

  TNS_encoder_15 u_enc (
    .datain (datain),
    .clock  (clock),
    .tsv    (tsv),
    .reset  (reset)
  );

  TNS_dec_15 u_dec (
    .tsv     (tsv),
    .dataout (dataout)
  );

endmodule

// File: tb/tb_tns15_codec.sv
// ---------------------------------------------------------------------------
// tb_tns15_codec
// Directed self-checking bench for tns15_codec. Inputs change on the
// falling edge; outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------

module tb_tns15_codec;

  logic [14:0] datain;
  logic        clock;
  logic [14:0] tsv;
  logic        reset;
  logic [14:0] dataout;

  int checks = 0;
  int passes = 0;

  tns15_codec dut (
    .datain  (datain),
    .clock   (clock),
    .tsv     (tsv),
    .reset   (reset),
    .dataout (dataout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d (0x%04h) expected=%0d (0x%04h)", tag, obs, obs, exp, exp);
  endtask

  // Apply one word (and reset level) for one rising edge, then settle.
  task automatic step(input logic [14:0] v, input logic r);
    @(negedge clock);
    datain = v;
    reset  = r;
    @(posedge clock);
    #1;
  endtask

  // Independent reference: digit map with b2 history from the expected word.
  function automatic logic [14:0] ref_enc(input int v, input logic [14:0] prev);
    logic [14:0] r;
    int rem;
    int d;
    r   = 15'd0;
    rem = v;
    for (int j = 0; j < 5; j++) begin
      d   = rem % 7;
      rem = rem / 7;
      case (d)
        0: r[3*j +: 3] = 3'b000;
        1: r[3*j +: 3] = 3'b010;
        2: r[3*j +: 3] = 3'b011;
        3: r[3*j +: 3] = 3'b100;
        4: r[3*j +: 3] = 3'b101;
        5: r[3*j +: 3] = 3'b111;
        default: r[3*j +: 3] = prev[3*j+2] ? 3'b001 : 3'b110;
      endcase
    end
    return r;
  endfunction

  initial begin
    logic [14:0] exp_tsv;
    logic [14:0] prev_tsv;
    logic        bad;
    int          v;

    datain = 15'd0;
    reset  = 1'b1;

    // Reset wins over data
    step(15'd12345, 1'b1);
    chk("reset_tsv", tsv, 15'd0);
    chk("reset_dataout", dataout, 15'd0);

    // Digit 6 alternates 110 / 001 in group 0
    step(15'd6, 1'b0);
    chk("six_first_tsv", tsv, 15'b000_000_000_000_110);
    chk("six_first_dataout", dataout, 15'd6);
    step(15'd6, 1'b0);
    chk("six_second_tsv", tsv, 15'b000_000_000_000_001);
    chk("six_second_dataout", dataout, 15'd6);

    // All-sixes word after reset
    step(15'd0, 1'b1);
    step(15'd16806, 1'b0);
    chk("max_first_tsv", tsv, 15'b110_110_110_110_110);
    chk("max_first_dataout", dataout, 15'd16806);
    step(15'd16806, 1'b0);
    chk("max_second_tsv", tsv, 15'b001_001_001_001_001);
    chk("max_second_dataout", dataout, 15'd16806);
    step(15'd16806, 1'b0);
    chk("max_third_tsv", tsv, 15'b110_110_110_110_110);

    // Mixed digits 2,1,5,4,3 (LS first) = 8829
    step(15'd8829, 1'b0);
    chk("mixed_tsv", tsv, 15'b100_101_111_010_011);
    chk("mixed_dataout", dataout, 15'd8829);

    // Mid-stream reset loses history: b2 was 1, but next 6 is 110
    step(15'd6, 1'b0);
    chk("hist_pre_tsv", tsv, 15'b000_000_000_000_110);
    step(15'd6, 1'b1);
    chk("hist_reset_tsv", tsv, 15'd0);
    step(15'd6, 1'b0);
    chk("hist_after_tsv", tsv, 15'b000_000_000_000_110);

    // Out-of-range handling
    step(15'd100, 1'b0);
    chk("load100_tsv", tsv, 15'b000_000_011_000_011);
    chk("load100_dataout", dataout, 15'd100);
    step(15'd16807, 1'b0);
`ifdef TNS_RANGE_CHECK_EN
    chk("oor16807_tsv", tsv, 15'b000_000_011_000_011);
    chk("oor16807_dataout", dataout, 15'd100);
`else
    chk("oor16807_tsv", tsv, 15'd0);
    chk("oor16807_dataout", dataout, 15'd0);
`endif
    step(15'd32767, 1'b0);
`ifdef TNS_RANGE_CHECK_EN
    chk("oor32767_dataout", dataout, 15'd100);
`else
    chk("oor32767_dataout", dataout, 15'd15960);
`endif

    // Random legal words: round trip, model encoding and crosstalk invariants
    step(15'd0, 1'b1);
    prev_tsv = 15'd0;
    for (int i = 0; i < 400; i++) begin
      v = (i % 50 == 0) ? 16806 : int'($urandom_range(0, 16806));
      exp_tsv = ref_enc(v, prev_tsv);
      step(15'(v), 1'b0);
      chk("rand_dataout", dataout, 15'(v));
      chk("rand_tsv", tsv, exp_tsv);
      bad = 1'b0;
      for (int j = 0; j < 5; j++) begin
        if (tsv[3*j +: 3] == 3'b001 && prev_tsv[3*j+2] == 1'b0) bad = 1'b1;
        if (tsv[3*j +: 3] == 3'b110 && prev_tsv[3*j+2] == 1'b1) bad = 1'b1;
      end
      chk("rand_invariant", {14'd0, bad}, 15'd0);
      prev_tsv = exp_tsv;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
